irq_ctrl: RTL

Interrupt controller between the board pushbuttons and the picoRV32 `irq` inputs inside the `vargen` SoC. It synchronises and debounces raw button lines, latches rising edges into a pending register, and gates them with a software mask. It drives level interrupts to the CPU and exposes its registers as a slave on the picoRV32 native memory bus. This replaces direct wiring of raw pushbuttons to the CPU interrupt lines.

---
 rtl/irq_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// Pushbutton interrupt controller for picoRV32: synchroniser, debouncer, W1C pending, mask, priority ID.
// Define IRQC_DEBOUNCE_EN to build the per-channel debounce counters and the DEBOUNCE register.
module irq_ctrl #(
    parameter int NUM_IRQ  = 3,
    parameter int DB_WIDTH = 16,
    parameter int DB_RESET = 16000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               sel,
    input  logic               mem_valid,
    input  logic [3:0]         mem_addr,
    input  logic [31:0]        mem_wdata,
    input  logic [3:0]         mem_wstrb,
    output logic               mem_ready,
    output logic [31:0]        mem_rdata,
    output logic [NUM_IRQ-1:0] irq_out,
    output logic [2:0]         irq_id
);

    logic [NUM_IRQ-1:0] sync1, s, d, d_q;
    logic [NUM_IRQ-1:0] pending, mask, clr;
    logic [31:0]        rd_mux, db_rd;
    logic [1:0]         reg_sel;
    logic               access, wr_en, rd_en;

    assign reg_sel = mem_addr[3:2];
    assign access  = mem_valid & sel & ~mem_ready;
    assign wr_en   = access & (|mem_wstrb);
    assign rd_en   = access & ~(|mem_wstrb);

    // NOTE: every register below uses non-blocking assignment so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= irq_in;
            s     <= sync1;
        end
    end

`ifdef IRQC_DEBOUNCE_EN
    logic [DB_WIDTH-1:0] db_val, db_limit;
    logic [DB_WIDTH-1:0] cnt [NUM_IRQ];

    // Terminal count; a programmed value of 0 behaves like 1.
    assign db_limit = (db_val == '0) ? '0 : db_val - DB_WIDTH'(1);
    assign db_rd    = 32'(db_val);

    always_ff @(posedge clk) begin
        if (reset) begin
            db_val <= DB_WIDTH'(DB_RESET);
        end else if (wr_en && reg_sel == 2'd3) begin
            for (int i = 0; i < DB_WIDTH; i++) begin
                if ((i < 8) ? mem_wstrb[0] : mem_wstrb[1])
                    db_val[i] <= mem_wdata[i];
            end
        end
    end

    // NOTE: the counter array is small register state, so it is cleared by reset like any other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            d <= '0;
            for (int i = 0; i < NUM_IRQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (s[i] == d[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] >= db_limit) begin
                    d[i]   <= s[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DB_WIDTH'(1);
                end
            end
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, mem_addr[1:0], mem_wdata};
`else
    logic [DB_WIDTH-1:0] db_reset_unused;
    logic                unused_ok;

    assign d               = s;
    assign db_rd           = '0;
    assign db_reset_unused = DB_WIDTH'(DB_RESET);
    assign unused_ok       = &{1'b0, mem_addr[1:0], mem_wdata, db_reset_unused};
`endif

    assign clr = (wr_en && reg_sel == 2'd0 && mem_wstrb[0]) ? mem_wdata[NUM_IRQ-1:0] : '0;

    // A rising edge of d outranks a simultaneous W1C of the same bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_q     <= '0;
            pending <= '0;
            mask    <= '0;
        end else begin
            d_q     <= d;
            pending <= (pending & ~clr) | (d & ~d_q);
            if (wr_en && reg_sel == 2'd1 && mem_wstrb[0])
                mask <= mem_wdata[NUM_IRQ-1:0];
        end
    end

    assign irq_out = pending & mask;

    // NOTE: defaults first so no path through the combinational blocks can infer a latch.
    always_comb begin
        irq_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_out[i]) irq_id = 3'(i + 1);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            2'd0:    rd_mux[NUM_IRQ-1:0] = pending;
            2'd1:    rd_mux[NUM_IRQ-1:0] = mask;
            2'd2:    rd_mux[2:0]         = irq_id;
            default: rd_mux              = db_rd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= mem_valid & sel & ~mem_ready;
            mem_rdata <= rd_en ? rd_mux : '0;
        end
    end

endmodule
